mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store engine between the ARMv4 core and a word-wide memory port.
//  Replaces the combinational size/extend decoder with a registered access sequencer:
//   - accepts one CPU request at a time and drives a req/ack memory handshake with wait states
//   - builds byte enables and store lane replication
//   - extracts, rotates and sign/zero-extends load data
//   - raises aborts on misalignment and on memory timeout
// PARAMETERS
//  ADDR_W        32   width of cpu_addr / mem_addr
//  WAIT_TIMEOUT  16   max cycles in REQ without mem_ack before abort; 0 = never time out
//  CNT_W         8    width of wait counter; must hold WAIT_TIMEOUT
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  cpu_req     in   1       request valid; accepted when cpu_req & cpu_ready at a clk edge
//  cpu_we      in   1       1 = store, 0 = load
//  cpu_size    in   2       00 byte, 01 halfword, 10 word, 11 treated as word
//  cpu_signed  in   1       sign-extend load (byte/half only)
//  cpu_fetch   in   1       instruction fetch: forces word load, unsigned, no rotate
//  cpu_addr    in   ADDR_W  byte address
//  cpu_wdata   in   32      store data, right-justified
//  cpu_ready   out  1       engine idle, may accept
//  cpu_done    out  1       one-cycle pulse: access completed, cpu_rdata valid
//  cpu_abort   out  1       one-cycle pulse: access aborted (misalign or timeout)
//  cpu_rdata   out  32      load result, held until next cpu_done
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       memory write strobe qualifier
//  mem_addr    out  ADDR_W  word-aligned address ({cpu_addr[ADDR_W-1:2],2'b00})
//  mem_be      out  4       byte enables, bit i = byte lane i (little-endian)
//  mem_wdata   out  32      lane-replicated store data
//  mem_rdata   in   32      read data, sampled on the edge mem_ack is high
//  mem_ack     in   1       memory completes current request
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE.
//   - outputs: cpu_ready=1, cpu_done=0, cpu_abort=0, cpu_rdata=0
//   - memory port: mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
//   - counter: wait counter=0
//  FSM states: IDLE, REQ, RESP, ABRT.
//   IDLE: cpu_ready=1. On accept, latch request fields.
//    - halfword with addr[0]=1 -> ABRT, no memory access
//    - otherwise -> REQ
//   REQ: mem_req=1, mem_addr/mem_we/mem_be/mem_wdata stable, cpu_ready=0.
//    - mem_ack=1 at edge: capture mem_rdata, -> RESP
//    - else counter++; counter==WAIT_TIMEOUT-1 (WAIT_TIMEOUT!=0) -> ABRT
//    - mem_ack in the timeout cycle wins: -> RESP
//   RESP: cpu_done=1 one cycle, cpu_rdata valid, mem_req=0 -> IDLE.
//   ABRT: cpu_abort=1 one cycle, cpu_rdata unchanged, mem_req=0 -> IDLE.
//  cpu_req while cpu_ready=0 is ignored, not queued.
//  Latency: accept at edge E0; mem_req high after E0; earliest ack at E1; cpu_done after E1.
//   Zero-wait access = 2 cycles accept-to-done; each wait state adds 1.
//  Store lanes:
//   - byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}
//   - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
//   - word: be = 1111, wdata unchanged; addr[1:0] ignored (force-aligned)
//  Loads: mem_we=0, be=1111. Result from captured word w:
//   - byte: w >> 8*addr[1:0], low 8 bits extended per cpu_signed
//   - half: addr[1] selects upper/lower 16 bits, extended per cpu_signed
//   - word: ARMv4 rotate-right of w by 8*addr[1:0]; fetch never rotates
//  Reset mid-access: mem_req drops immediately; no done/abort is issued for the lost access.
// TESTING
//  1. Word load addr=0x100, ack 1 cycle after mem_req, mem_rdata=0xDEADBEEF
//     -> cpu_done 2 cycles after accept, cpu_rdata=0xDEADBEEF.
//  2. Signed byte load addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80; unsigned -> 0x00000080.
//  3. Half store addr=0x202, wdata=0x0000ABCD
//     -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200.
//  4. Unaligned word load addr=0x101, mem_rdata=0x44332211 -> rdata=0x11443322; cpu_fetch=1 -> 0x44332211.
//  5. Half load addr=0x301 -> cpu_abort pulse next cycle, mem_req never asserted, cpu_rdata unchanged.
//  6. WAIT_TIMEOUT=4, no ack -> mem_req high 4 cycles then cpu_abort;
//     repeat with ack in cycle 4 -> cpu_done, no abort; rst_n low during REQ -> mem_req=0 at once.

Source files
------------

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Registered load/store sequencer between the CPU core and a word-wide
//   memory port. It takes one CPU request at a time and runs a req/ack
//   handshake with wait states toward memory. It builds byte enables and
//   replicated store lanes for stores. For loads it extracts, rotates and
//   extends the returned word. It aborts on a misaligned halfword and on a
//   memory timeout.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     cpu_req/we/size/signed/fetch/addr/wdata    request from core
//     cpu_ready         idle, request may be accepted
//     cpu_done          1-cycle pulse, access completed, cpu_rdata valid
//     cpu_abort         1-cycle pulse, access aborted
//     cpu_rdata         load result, held until the next completed load
//     mem_req/we/addr/be/wdata   memory request, held until mem_ack
//     mem_rdata, mem_ack         memory response
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W       = 32,
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic              cpu_fetch,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_abort,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ABRT = 2'd3;

    // Normalised access sizes (size 11 folds into word).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic              fetch_reg;
    logic [1:0]        lane_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_be_reg;
    logic [31:0]       mem_wdata_reg;
    logic [31:0]       rdata_reg;

    // Request decode, evaluated while idle
    logic        accept;
    logic [1:0]  size_next;
    logic        we_next;
    logic        misalign;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // A fetch is always an unsigned, unrotated word load.
    assign accept    = cpu_req && (state_reg == S_IDLE);
    assign size_next = (cpu_fetch || cpu_size[1]) ? SZ_WORD : cpu_size;
    assign we_next   = cpu_we && !cpu_fetch;
    assign misalign  = (size_next == SZ_HALF) && cpu_addr[0];

    // Per-lane enable and store data. Loads always read the full word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign be_next[gi] = !we_next
                              || (size_next == SZ_WORD)
                              || ((size_next == SZ_BYTE) && (cpu_addr[1:0] == 2'(gi)))
                              || ((size_next == SZ_HALF) && (cpu_addr[1] == 1'(gi / 2)));
            assign wdata_next[8*gi +: 8] =
                (size_next == SZ_BYTE) ? cpu_wdata[7:0] :
                (size_next == SZ_HALF) ? cpu_wdata[8*(gi % 2) +: 8] :
                                         cpu_wdata[8*gi +: 8];
        end
    endgenerate

    // Load result from the word currently on mem_rdata
    logic [31:0] shifted;
    logic [63:0] rot64;
    logic [15:0] half_sel;
    logic [31:0] load_next;

    always_comb begin
        shifted   = mem_rdata >> {lane_reg, 3'b000};
        // Rotate-right implemented as a shift of the doubled word.
        rot64     = {mem_rdata, mem_rdata} >> {lane_reg, 3'b000};
        half_sel  = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_next = fetch_reg ? mem_rdata : rot64[31:0];
        case (size_reg)
            SZ_BYTE: load_next = {{24{signed_reg & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_next = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    // The cycle being evaluated is the WAIT_TIMEOUT-th cycle without ack.
    logic timeout;
    assign timeout = (WAIT_TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            size_reg      <= SZ_BYTE;
            signed_reg    <= 1'b0;
            fetch_reg     <= 1'b0;
            lane_reg      <= 2'b00;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        size_reg      <= size_next;
                        signed_reg    <= cpu_signed && !cpu_fetch;
                        fetch_reg     <= cpu_fetch;
                        lane_reg      <= cpu_addr[1:0];
                        mem_we_reg    <= we_next;
                        mem_addr_reg  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_be_reg    <= be_next;
                        mem_wdata_reg <= wdata_next;
                        wait_cnt_reg  <= '0;
                        state_reg     <= misalign ? S_ABRT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        // Stores leave the previous load result in place.
                        if (!mem_we_reg) begin
                            rdata_reg <= load_next;
                        end
                        state_reg <= S_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                        if (timeout) begin
                            state_reg <= S_ABRT;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cpu_ready = (state_reg == S_IDLE);
    assign cpu_done  = (state_reg == S_RESP);
    assign cpu_abort = (state_reg == S_ABRT);
    assign cpu_rdata = rdata_reg;
    assign mem_req   = (state_reg == S_REQ);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Table of CPU accesses with expected memory-side signals and results;
//   the expected done/abort/result is queued when a request is driven and
//   matched when the DUT pulses cpu_done or cpu_abort. Timeout, ack on the
//   last wait cycle and reset mid-access are covered by hand sequences.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic        cpu_signed = 1'b0;
    logic        cpu_fetch = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_done, cpu_abort;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .WAIT_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_fetch(cpu_fetch), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .cpu_abort(cpu_abort), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic        fetch;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_abort;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic        abort;
        logic        chk_rdata;
        logic [31:0] rdata;
    } sb_t;

    sb_t         exp_q[$];
    sb_t         mon_e;
    logic [31:0] last_rdata = '0;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic fetch, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int delay, input logic exp_abort,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.fetch = fetch;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.exp_abort = exp_abort; v.exp_rdata = exp_rdata; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Scoreboard: every done/abort pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (cpu_done || cpu_abort) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {31'b0, cpu_done | cpu_abort}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_abort", {31'b0, cpu_abort}, {31'b0, mon_e.abort});
                chk("sb_done", {31'b0, cpu_done}, {31'b0, !mon_e.abort});
                if (mon_e.chk_rdata) chk("sb_rdata", cpu_rdata, mon_e.rdata);
                $display("txn done=%0b abort=%0b rdata=0x%08h", cpu_done, cpu_abort, cpu_rdata);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic fetch, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
        cpu_fetch = fetch; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        sb_t e;
        drive_req(v.we, v.size, v.sgn, v.fetch, v.addr, v.wdata);
        e.abort = v.exp_abort;
        e.chk_rdata = !v.we || v.exp_abort;
        e.rdata = v.exp_abort ? last_rdata : v.exp_rdata;
        exp_q.push_back(e);
        @(negedge clk);
        cpu_req = 1'b0;
        chk($sformatf("v%0d_ready_busy", idx), {31'b0, cpu_ready}, 32'd0);
        if (v.exp_abort) begin
            chk($sformatf("v%0d_no_mem_req", idx), {31'b0, mem_req}, 32'd0);
        end else begin
            chk($sformatf("v%0d_mem_req", idx), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
            chk($sformatf("v%0d_mem_be", idx), {28'b0, mem_be}, {28'b0, v.exp_be});
            chk($sformatf("v%0d_mem_we", idx), {31'b0, mem_we}, {31'b0, v.we && !v.fetch});
            if (v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
            // Wait states; a stray request meanwhile must be ignored.
            for (int i = 0; i < v.delay; i++) begin
                cpu_req = 1'b1; cpu_addr = 32'hFFC;
                @(negedge clk);
                chk($sformatf("v%0d_wait%0d_req", idx, i), {31'b0, mem_req}, 32'd1);
                chk($sformatf("v%0d_wait%0d_addr", idx, i), mem_addr, v.exp_addr);
            end
            cpu_req = 1'b0;
            mem_ack = 1'b1; mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk($sformatf("v%0d_done", idx), {31'b0, cpu_done}, 32'd1);
            chk($sformatf("v%0d_req_drop", idx), {31'b0, mem_req}, 32'd0);
            if (!v.we) last_rdata = v.exp_rdata;
        end
    endtask

    vec_t vecs[15];

    initial begin
        //            we   sz     sg   fe   addr    wdata         rdata         d  ab   exp_rdata     exp_addr  be       exp_wdata
        vecs[0]  = mk(0, 2'b10, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0);
        vecs[1]  = mk(0, 2'b00, 1, 0, 32'h103, 32'h0,        32'h80112233, 0, 0, 32'hFFFFFF80, 32'h100, 4'b1111, 32'h0);
        vecs[2]  = mk(0, 2'b00, 0, 0, 32'h103, 32'h0,        32'h80112233, 1, 0, 32'h00000080, 32'h100, 4'b1111, 32'h0);
        vecs[3]  = mk(1, 2'b01, 0, 0, 32'h202, 32'h0000ABCD, 32'h0,        0, 0, 32'h0,        32'h200, 4'b1100, 32'hABCDABCD);
        vecs[4]  = mk(0, 2'b10, 0, 0, 32'h101, 32'h0,        32'h44332211, 0, 0, 32'h11443322, 32'h100, 4'b1111, 32'h0);
        vecs[5]  = mk(0, 2'b00, 1, 1, 32'h101, 32'h0,        32'h44332211, 1, 0, 32'h44332211, 32'h100, 4'b1111, 32'h0);
        vecs[6]  = mk(0, 2'b01, 0, 0, 32'h301, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
        vecs[7]  = mk(1, 2'b00, 0, 0, 32'h001, 32'h12345678, 32'h0,        2, 0, 32'h0,        32'h000, 4'b0010, 32'h78787878);
        vecs[8]  = mk(0, 2'b01, 1, 0, 32'h302, 32'h0,        32'h8001FFFF, 1, 0, 32'hFFFF8001, 32'h300, 4'b1111, 32'h0);
        vecs[9]  = mk(0, 2'b01, 0, 0, 32'h300, 32'h0,        32'h8001F00F, 0, 0, 32'h0000F00F, 32'h300, 4'b1111, 32'h0);
        vecs[10] = mk(1, 2'b10, 0, 0, 32'h107, 32'hCAFEF00D, 32'h0,        0, 0, 32'h0,        32'h104, 4'b1111, 32'hCAFEF00D);
        // ack on the 4th REQ cycle, i.e. the timeout cycle: completes normally
        vecs[11] = mk(0, 2'b11, 0, 0, 32'h400, 32'h0,        32'h01020304, 3, 0, 32'h01020304, 32'h400, 4'b1111, 32'h0);
        vecs[12] = mk(0, 2'b00, 1, 0, 32'h102, 32'h0,        32'h007F0000, 0, 0, 32'h0000007F, 32'h100, 4'b1111, 32'h0);
        vecs[13] = mk(1, 2'b01, 0, 0, 32'h205, 32'h1111,     32'h0,        0, 1, 32'h0,        32'h0,   4'b0000, 32'h0);
        vecs[14] = mk(0, 2'b10, 0, 0, 32'h103, 32'h0,        32'h44332211, 0, 0, 32'h33221144, 32'h100, 4'b1111, 32'h0);

        // Reset values, checked while rst_n is still low
        #1;
        chk("rst_ready", {31'b0, cpu_ready}, 32'd1);
        chk("rst_done_abort", {30'b0, cpu_done, cpu_abort}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req_we", {30'b0, mem_req, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: no ack, mem_req held for 4 cycles then abort
        begin
            sb_t e;
            drive_req(1'b0, 2'b10, 1'b0, 1'b0, 32'h600, 32'h0);
            e.abort = 1'b1; e.chk_rdata = 1'b1; e.rdata = last_rdata;
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                cpu_req = 1'b0;
                chk($sformatf("to_req_cycle%0d", i), {31'b0, mem_req}, 32'd1);
            end
            @(negedge clk);
            chk("to_abort", {31'b0, cpu_abort}, 32'd1);
            chk("to_req_drop", {31'b0, mem_req}, 32'd0);
        end

        // Reset in REQ: mem_req falls at once, no pulse for the lost access
        drive_req(1'b0, 2'b10, 1'b0, 1'b0, 32'h700, 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        chk("mid_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_ready", {31'b0, cpu_ready}, 32'd1);
        chk("mid_rst_be", {28'b0, mem_be}, 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        last_rdata = '0;

        // Unit is usable again after the reset
        run_vec(100, vecs[0]);
        repeat (2) @(negedge clk);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
